// File: rtl/jesd_rx_pkg.sv
// Shared constants and state encodings for the JESD204B receive lane aligner.
package jesd_rx_pkg;

    localparam logic [7:0] K28_5  = 8'hBC;   // /K/ comma, code-group sync
    localparam logic [7:0] K28_0  = 8'h1C;   // /R/, start of ILAS multiframe
    localparam logic [7:0] K28_3  = 8'h7C;   // /A/, end of multiframe
    localparam int         OCTETS = 4;       // octets per lane word
    localparam int         WORD_W = 8 * OCTETS;

    typedef enum logic {INIT, DATA} cgs_state_t;
    typedef enum logic {WAIT_R, RUN} ilas_state_t;

endpackage

// File: rtl/jesd_rx_lane_cgs.sv
// One JESD lane: code-group sync FSM, ILAS /R/ detect and deskew FIFO.
//
// CGS FSM
//   state | meaning
//   INIT  | hunting for CGS_WORDS consecutive all-K28.5 words
//   DATA  | lane synchronised; ERR_LIMIT consecutive error words drop it
//
// ILAS FSM
//   state  | meaning
//   WAIT_R | SYNC~ released or not, waiting for /R/ in octet 0
//   RUN    | /R/ seen; every word goes into the deskew FIFO
module jesd_rx_lane_cgs
    import jesd_rx_pkg::*;
#(
    parameter int CGS_WORDS = 4,
    parameter int ERR_LIMIT = 3,
    parameter int BUF_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    input  logic [WORD_W-1:0] rx_data,
    input  logic [OCTETS-1:0] rx_charisk,
    input  logic [OCTETS-1:0] rx_disperr,
    input  logic [OCTETS-1:0] rx_notintable,
    input  logic              sync_n,
    input  logic              flush,
    input  logic              pop,
    output logic              cgs_done,
    output logic              run,
    output logic              wr,
    output logic              full,
    output logic [WORD_W-1:0] rd_data
);

    localparam int CW   = $clog2(CGS_WORDS + 1);
    localparam int EW   = $clog2(ERR_LIMIT + 1);
    localparam int AW   = $clog2(BUF_DEPTH);
    localparam int FW   = AW + 1;
    localparam logic [CW-1:0] CGS_LOAD = CW'(CGS_WORDS - 1);
    localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_LIMIT - 1);
    localparam logic [FW-1:0] DEPTH    = FW'(BUF_DEPTH);

    cgs_state_t        cgs_state;
    ilas_state_t       ilas_state;
    logic [CW-1:0]     k_cnt;
    logic [EW-1:0]     err_cnt;
    logic [WORD_W-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [FW-1:0]     fill;

    logic is_k, is_err, is_r, start, do_wr, do_pop;

    assign is_k   = (rx_data == {OCTETS{K28_5}}) && (rx_charisk == '1);
    assign is_err = |(rx_disperr | rx_notintable);
    assign is_r   = (rx_data[7:0] == K28_0) && rx_charisk[0];
    assign start  = (ilas_state == WAIT_R) && sync_n && is_r;
    assign wr     = (ilas_state == RUN) || start;
    assign full   = (fill == DEPTH);
    // A full FIFO may still take a word when it is popped in the same cycle.
    assign do_wr  = wr && !flush && (!full || pop);
    assign do_pop = pop && (fill != '0);

    assign cgs_done = (cgs_state == DATA);
    assign run      = (ilas_state == RUN);
    assign rd_data  = mem[rd_ptr];

    // CGS FSM with down-counters for the K-word run and the error run.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cgs_state <= INIT;
            k_cnt     <= CGS_LOAD;
            err_cnt   <= ERR_LOAD;
        end else if (!enable_i) begin
            cgs_state <= INIT;
            k_cnt     <= CGS_LOAD;
            err_cnt   <= ERR_LOAD;
        end else begin
            case (cgs_state)
                INIT: begin
                    if (!is_k) begin
                        k_cnt <= CGS_LOAD;
                    end else if (k_cnt == '0) begin
                        cgs_state <= DATA;
                        k_cnt     <= CGS_LOAD;
                        err_cnt   <= ERR_LOAD;
                    end else begin
                        k_cnt <= k_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (!is_err) begin
                        err_cnt <= ERR_LOAD;
                    end else if (err_cnt == '0) begin
                        cgs_state <= INIT;
                        err_cnt   <= ERR_LOAD;
                    end else begin
                        err_cnt <= err_cnt - 1'b1;
                    end
                end
                default: cgs_state <= INIT;
            endcase
        end
    end

    // ILAS start detect and FIFO pointers; flush wins over a same-cycle /R/.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ilas_state <= WAIT_R;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
        end else if (flush) begin
            ilas_state <= WAIT_R;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
        end else begin
            if (start) ilas_state <= RUN;
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // FIFO storage, not reset: contents are only read behind valid pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr] <= rx_data;
    end

endmodule

// File: rtl/jesd_rx_lane_align.sv
// JESD204B receive front-end: per-lane CGS, SYNC~ generation and lane deskew.
module jesd_rx_lane_align
    import jesd_rx_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CGS_WORDS = 4,
    parameter int ERR_LIMIT = 3,
    parameter int BUF_DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    enable_i,
    input  logic [32*LANES-1:0]     rx_data_i,
    input  logic [4*LANES-1:0]      rx_charisk_i,
    input  logic [4*LANES-1:0]      rx_disperr_i,
    input  logic [4*LANES-1:0]      rx_notintable_i,
    output logic                    sync_n_o,
    output logic [LANES-1:0]        lane_cgs_o,
    output logic                    aligned_o,
    output logic [32*LANES-1:0]     data_o,
    output logic                    valid_o,
    output logic                    overflow_o
);

    logic [LANES-1:0]        cgs_vec, run_vec, wr_vec, full_vec;
    logic [32*LANES-1:0]     rd_vec;
    logic                    all_started, ovf_event, flush, pop;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        jesd_rx_lane_cgs #(
            .CGS_WORDS (CGS_WORDS),
            .ERR_LIMIT (ERR_LIMIT),
            .BUF_DEPTH (BUF_DEPTH)
        ) u_lane (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .enable_i      (enable_i),
            .rx_data       (rx_data_i[WORD_W*g +: WORD_W]),
            .rx_charisk    (rx_charisk_i[OCTETS*g +: OCTETS]),
            .rx_disperr    (rx_disperr_i[OCTETS*g +: OCTETS]),
            .rx_notintable (rx_notintable_i[OCTETS*g +: OCTETS]),
            .sync_n        (sync_n_o),
            .flush         (flush),
            .pop           (pop),
            .cgs_done      (cgs_vec[g]),
            .run           (run_vec[g]),
            .wr            (wr_vec[g]),
            .full          (full_vec[g]),
            .rd_data       (rd_vec[WORD_W*g +: WORD_W])
        );
    end

    assign lane_cgs_o  = cgs_vec;
    assign all_started = &run_vec;
    // Overflow takes priority over a same-cycle final /R/: all_started is still low.
    assign ovf_event   = !all_started && |(wr_vec & full_vec);
    assign flush       = !enable_i || !(&cgs_vec) || ovf_event;
    assign pop         = all_started && !flush;
    assign aligned_o   = valid_o;

    // SYNC~ released only while enabled and every lane has code-group sync.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_n_o <= 1'b0;
        else          sync_n_o <= enable_i && (&cgs_vec);
    end

    // Sticky deskew overflow, cleared only by disabling the link.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)       overflow_o <= 1'b0;
        else if (!enable_i) overflow_o <= 1'b0;
        else if (ovf_event) overflow_o <= 1'b1;
    end

    // Aligned output stage: one word from every FIFO per cycle once all lanes run.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (pop) begin
            valid_o <= 1'b1;
            data_o  <= rd_vec;
        end else begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end
    end

endmodule

// File: tb/tb_jesd_rx_lane_align.sv
// Directed testbench for jesd_rx_lane_align (4 lanes, CGS 4, error limit 3, depth 8).
module tb_jesd_rx_lane_align;
    import jesd_rx_pkg::*;

    localparam int LANES     = 4;
    localparam int CGS_WORDS = 4;
    localparam int ERR_LIMIT = 3;
    localparam int BUF_DEPTH = 8;

    logic                clk_i = 1'b0;
    logic                rst_n_i;
    logic                enable_i;
    logic [32*LANES-1:0] rx_data_i;
    logic [4*LANES-1:0]  rx_charisk_i;
    logic [4*LANES-1:0]  rx_disperr_i;
    logic [4*LANES-1:0]  rx_notintable_i;
    logic                sync_n_o;
    logic [LANES-1:0]    lane_cgs_o;
    logic                aligned_o;
    logic [32*LANES-1:0] data_o;
    logic                valid_o;
    logic                overflow_o;

    logic [31:0] ld  [LANES];
    logic [3:0]  lk  [LANES];
    logic [3:0]  lde [LANES];
    logic [3:0]  lni [LANES];
    int          sk  [LANES];

    int checks = 0;
    int errors = 0;

    jesd_rx_lane_align #(
        .LANES     (LANES),
        .CGS_WORDS (CGS_WORDS),
        .ERR_LIMIT (ERR_LIMIT),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .enable_i        (enable_i),
        .rx_data_i       (rx_data_i),
        .rx_charisk_i    (rx_charisk_i),
        .rx_disperr_i    (rx_disperr_i),
        .rx_notintable_i (rx_notintable_i),
        .sync_n_o        (sync_n_o),
        .lane_cgs_o      (lane_cgs_o),
        .aligned_o       (aligned_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        rx_data_i       = '0;
        rx_charisk_i    = '0;
        rx_disperr_i    = '0;
        rx_notintable_i = '0;
        for (int i = 0; i < LANES; i++) begin
            rx_data_i[32*i +: 32]      = ld[i];
            rx_charisk_i[4*i +: 4]     = lk[i];
            rx_disperr_i[4*i +: 4]     = lde[i];
            rx_notintable_i[4*i +: 4]  = lni[i];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Lane word k after /R/: {tag, k, octet0}, octet0 is /R/ only for k = 0.
    function automatic logic [31:0] wd(input logic [7:0] tag, input int k);
        logic [15:0] kk;
        kk = k[15:0];
        wd = {tag, kk, (k == 0) ? K28_0 : 8'h00};
    endfunction

    function automatic logic [32*LANES-1:0] exp_data(input logic [7:0] base, input int j);
        logic [32*LANES-1:0] e;
        e = '0;
        for (int i = 0; i < LANES; i++) e[32*i +: 32] = wd(base + 8'(i), j);
        return e;
    endfunction

    task automatic drive_k(input int i);
        ld[i] = 32'hBCBC_BCBC; lk[i] = 4'hF; lde[i] = 4'h0; lni[i] = 4'h0;
    endtask

    task automatic drive_w(input int i, input logic [7:0] tag, input int k);
        ld[i] = wd(tag, k); lk[i] = (k == 0) ? 4'h1 : 4'h0; lde[i] = 4'h0; lni[i] = 4'h0;
    endtask

    task automatic do_cgs(input string tag);
        for (int i = 0; i < LANES; i++) drive_k(i);
        repeat (4) tick();
        chk({tag, "_cgs"}, lane_cgs_o, 4'hF);
        tick();
        chk({tag, "_sync"}, sync_n_o, 1'b1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < LANES; i++) begin
            ld[i] = '0; lk[i] = '0; lde[i] = '0; lni[i] = '0;
        end
        rst_n_i  = 1'b1;
        enable_i = 1'b0;
        #2 rst_n_i = 1'b0;
        repeat (2) tick();
        chk("rst_sync", sync_n_o, 1'b0);
        chk("rst_cgs", lane_cgs_o, 4'h0);
        chk("rst_aligned", aligned_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, '0);
        chk("rst_ovf", overflow_o, 1'b0);
        rst_n_i  = 1'b1;
        enable_i = 1'b1;
        tick();

        // Lanes 0,1,3 send K; lane 2 only ever manages three in a row.
        for (int c = 0; c < 12; c++) begin
            drive_k(0); drive_k(1); drive_k(3);
            if (c % 4 == 3) drive_w(2, 8'h22, c); else drive_k(2);
            tick();
            if (c == 2) chk("cgs_3k", lane_cgs_o, 4'h0);
            if (c == 3) chk("cgs_4k", lane_cgs_o, 4'hB);
        end
        chk("cgs_l2_stuck", lane_cgs_o, 4'hB);
        chk("cgs_l2_sync", sync_n_o, 1'b0);

        // Lane 2 now gets four consecutive K words.
        for (int i = 0; i < LANES; i++) drive_k(i);
        repeat (3) tick();
        chk("cgs_l2_3k", lane_cgs_o, 4'hB);
        tick();
        chk("cgs_all", lane_cgs_o, 4'hF);
        chk("sync_n1", sync_n_o, 1'b0);
        tick();
        chk("sync_n2", sync_n_o, 1'b1);

        // Deskew: /R/ on lanes 0..3 with skews 0,1,3,2; last /R/ in cycle 3.
        sk[0] = 0; sk[1] = 1; sk[2] = 3; sk[3] = 2;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < LANES; i++) begin
                if (c < sk[i]) drive_k(i); else drive_w(i, 8'h10 + 8'(i), c - sk[i]);
            end
            tick();
            cyc = c + 1;
            chk("align_valid", valid_o, (cyc >= 5) ? 1'b1 : 1'b0);
            chk("align_aligned", aligned_o, (cyc >= 5) ? 1'b1 : 1'b0);
            if (cyc >= 5) chk("align_data", data_o, exp_data(8'h10, cyc - 5));
        end
        chk("align_ovf", overflow_o, 1'b0);

        // Disable clears everything.
        enable_i = 1'b0;
        tick();
        chk("dis_sync", sync_n_o, 1'b0);
        chk("dis_cgs", lane_cgs_o, 4'h0);
        chk("dis_valid", valid_o, 1'b0);
        chk("dis_data", data_o, '0);
        enable_i = 1'b1;
        do_cgs("ovf");

        // Skew of BUF_DEPTH words on lane 3: overflow in the same cycle as its /R/.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 3; i++) drive_w(i, 8'h20 + 8'(i), c);
            if (c < 8) drive_k(3); else drive_w(3, 8'h23, c - 8);
            tick();
            cyc = c + 1;
            chk("ovf_flag", overflow_o, (cyc >= 9) ? 1'b1 : 1'b0);
            chk("ovf_aligned", aligned_o, 1'b0);
        end

        // Realign with skew 1 on lane 3, then lane 1 error bursts of 2 and 3.
        for (int c = 0; c < 19; c++) begin
            for (int i = 0; i < 3; i++) drive_w(i, 8'h30 + 8'(i), c);
            if (c < 1) drive_k(3); else drive_w(3, 8'h33, c - 1);
            if (c == 8 || c == 9 || c == 12 || c == 13 || c == 14) lde[1] = 4'h1;
            tick();
            cyc = c + 1;
            chk("re_ovf_sticky", overflow_o, 1'b1);
            chk("re_cgs", lane_cgs_o, (cyc <= 14) ? 4'hF : 4'hD);
            chk("re_sync", sync_n_o, (cyc <= 15) ? 1'b1 : 1'b0);
            if (cyc <= 14) begin
                chk("re_valid", valid_o, (cyc >= 3) ? 1'b1 : 1'b0);
                if (cyc >= 3) chk("re_data", data_o, exp_data(8'h30, cyc - 3));
            end
            if (cyc >= 16) begin
                chk("err_valid", valid_o, 1'b0);
                chk("err_aligned", aligned_o, 1'b0);
            end
        end

        // Disabling clears the sticky overflow.
        enable_i = 1'b0;
        tick();
        chk("dis2_ovf", overflow_o, 1'b0);
        chk("dis2_cgs", lane_cgs_o, 4'h0);
        enable_i = 1'b1;
        do_cgs("ar");

        // Zero-skew alignment, then asynchronous reset mid-stream.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < LANES; i++) drive_w(i, 8'h40 + 8'(i), c);
            tick();
        end
        chk("ar_valid", valid_o, 1'b1);
        chk("ar_data", data_o, exp_data(8'h40, 2));
        #3 rst_n_i = 1'b0;
        #1;
        chk("ar_sync", sync_n_o, 1'b0);
        chk("ar_cgs", lane_cgs_o, 4'h0);
        chk("ar_aligned", aligned_o, 1'b0);
        chk("ar_valid0", valid_o, 1'b0);
        chk("ar_data0", data_o, '0);
        chk("ar_ovf", overflow_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
